// File: rtl/intdump_ctrl.sv
// Integrate-and-dump controller: sums N signed samples and presents the
// exact sum through a one-deep valid/ready output register.
module intdump_ctrl #(
   parameter int w  = 10,
   parameter int cw = 8,
   parameter int ow = w + cw
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic          stop,
   input  logic          cont,
   input  logic [cw-1:0] len,
   input  logic [w-1:0]  din,
   input  logic          din_vld,
   output logic [ow-1:0] dout,
   output logic          dout_vld,
   input  logic          dout_rdy,
   output logic          busy,
   output logic          ovr
);

   typedef enum logic {IDLE, ACC} state_t;

   state_t        state_q, state_d;
   logic [ow-1:0] acc_q, acc_d;
   logic [cw-1:0] cnt_q, cnt_d;
   logic [cw-1:0] n_q, n_d;
   logic          cont_q, cont_d;
   logic [ow-1:0] dout_q, dout_d;
   logic          vld_q, vld_d;
   logic          ovr_q, ovr_d;

   logic [ow-1:0] sum;
   logic          last;
   logic          load;

   assign sum  = acc_q + {{(ow-w){din[w-1]}}, din};
   assign last = (cnt_q == n_q - cw'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         cont_q  <= 1'b0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         cont_q  <= cont_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      cont_d  = cont_q;
      dout_d  = dout_q;
      vld_d   = vld_q;
      ovr_d   = ovr_q;
      load    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && len != '0) begin
               n_d     = len;
               cont_d  = cont;
               acc_d   = '0;
               cnt_d   = '0;
               ovr_d   = 1'b0;
               state_d = ACC;
            end
         end
         ACC: begin
            // stop wins over a coincident sample, even the final one
            if (stop) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (din_vld) begin
               if (last) begin
                  load    = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = cont_q ? ACC : IDLE;
               end else begin
                  acc_d = sum;
                  cnt_d = cnt_q + cw'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (vld_q && dout_rdy) vld_d = 1'b0;
      if (load) begin
         dout_d = sum;
         vld_d  = 1'b1;
         if (vld_q && !dout_rdy) ovr_d = 1'b1;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = vld_q;
   assign busy     = (state_q == ACC);
   assign ovr      = ovr_q;

endmodule

// File: tb/tb_intdump_ctrl.sv
// Scoreboard bench for intdump_ctrl: directed dumps are queued as expected
// values and a monitor compares every accepted output.
module tb_intdump_ctrl;

   localparam int W  = 10;
   localparam int CW = 8;
   localparam int OW = W + CW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start, stop, cont;
   logic [CW-1:0] len;
   logic [W-1:0]  din;
   logic          din_vld;
   logic [OW-1:0] dout;
   logic          dout_vld;
   logic          dout_rdy;
   logic          busy;
   logic          ovr;

   int n_chk  = 0;
   int n_fail = 0;
   longint exp_q[$];

   intdump_ctrl #(.w(W), .cw(CW), .ow(OW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .stop(stop),
      .cont(cont), .len(len), .din(din), .din_vld(din_vld),
      .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
      .busy(busy), .ovr(ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // monitor: every handshake must match the oldest queued dump
   always @(negedge clk) begin
      if (rstn && dout_vld && dout_rdy) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_dump: got %0d expected none",
                     $signed(dout));
         end else begin
            chk("dump", longint'($signed(dout)), exp_q.pop_front());
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic go(input int n, input logic c);
      start = 1'b1;
      len   = CW'(n);
      cont  = c;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int v);
      din     = W'(v);
      din_vld = 1'b1;
      tick();
      din_vld = 1'b0;
   endtask

   task automatic halt;
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
      len = '0; din = '0; din_vld = 1'b0; dout_rdy = 1'b1;
      #12;
      chk("rst_vld", dout_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", ovr, 0);
      chk("rst_dout", dout, 0);
      rstn = 1'b1;
      tick();

      // single shot N=4
      exp_q.push_back(10);
      go(4, 0);
      chk("ss_busy", busy, 1);
      feed(5); feed(-3); feed(7);
      chk("ss_novld", dout_vld, 0);
      feed(1);
      chk("ss_vld", dout_vld, 1);
      chk("ss_idle", busy, 0);
      tick();
      chk("ss_vld_drop", dout_vld, 0);

      // continuous N=3, max positive samples
      exp_q.push_back(1533);
      exp_q.push_back(1533);
      go(3, 1);
      feed(511); feed(511); feed(511);
      chk("ct_vld1", dout_vld, 1);
      feed(511);
      chk("ct_gap", dout_vld, 0);
      feed(511); feed(511);
      chk("ct_vld2", dout_vld, 1);
      chk("ct_busy", busy, 1);
      halt();
      chk("ct_stop", busy, 0);

      // N=255 of most negative sample
      exp_q.push_back(-130560);
      go(255, 0);
      for (int i = 0; i < 255; i++) feed(-512);
      chk("neg_dout", longint'($signed(dout)), -130560);
      tick();

      // backpressure overwrite
      dout_rdy = 1'b0;
      go(2, 1);
      feed(1); feed(2);
      chk("bp_d1", dout, 3);
      chk("bp_ovr0", ovr, 0);
      feed(3); feed(4);
      chk("bp_d2", dout, 7);
      chk("bp_ovr1", ovr, 1);
      chk("bp_vld", dout_vld, 1);
      halt();
      chk("bp_hold", dout, 7);
      exp_q.push_back(7);
      dout_rdy = 1'b1;
      tick();
      chk("bp_sticky", ovr, 1);

      // len=0 start is ignored and leaves ovr alone
      go(0, 0);
      chk("l0_busy", busy, 0);
      chk("l0_ovr", ovr, 1);

      go(2, 0);
      chk("clr_ovr", ovr, 0);
      exp_q.push_back(2);
      feed(1); feed(1);
      tick();

      // N=1 continuous, load coincides with handshake
      go(1, 1);
      exp_q.push_back(5);   feed(5);
      exp_q.push_back(-7);  feed(-7);
      exp_q.push_back(511); feed(511);
      exp_q.push_back(-512); feed(-512);
      chk("n1_ovr", ovr, 0);
      halt();
      tick();

      // abort discards partial sum
      go(8, 0);
      feed(9); feed(9); feed(9);
      halt();
      chk("ab_busy", busy, 0);
      chk("ab_vld", dout_vld, 0);
      exp_q.push_back(8);
      go(2, 0);
      feed(4); feed(4);
      tick();

      // gapped valid
      exp_q.push_back(6);
      go(3, 0);
      feed(2);
      din = W'(99); tick(); tick();
      feed(2);
      din = W'(99); tick();
      feed(2);
      chk("gap_vld", dout_vld, 1);
      chk("gap_dout", dout, 6);
      tick();

      // asynchronous reset with pending dump and overrun
      dout_rdy = 1'b0;
      go(1, 1);
      feed(1); feed(2);
      chk("pre_ovr", ovr, 1);
      #2 rstn = 1'b0;
      #1;
      chk("ar_vld", dout_vld, 0);
      chk("ar_ovr", ovr, 0);
      chk("ar_busy", busy, 0);
      chk("ar_dout", dout, 0);
      #3 rstn = 1'b1;
      din = W'(7);
      din_vld = 1'b1;
      tick(); tick(); tick();
      din_vld = 1'b0;
      chk("post_busy", busy, 0);
      chk("post_vld", dout_vld, 0);
      chk("post_dout", dout, 0);
      tick();

      chk("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/intdump_ctrl.md
Name: intdump_ctrl

Overview:
- Integrate-and-dump controller that sequences a signed accumulator over a programmable number of input samples, then dumps the sum.
- Dumps go to a one-deep output register with a valid/ready handshake.
- Sits after the front-end integrator/decimation chain and feeds symbol-rate consumers (slicer, correlator).
- Supports single-shot and continuous operation, abort, and sticky overrun detection.

Parameters:
- w, 10, input sample width (signed two's complement).
- cw, 8, dump-length counter width; max dump length is 2^cw-1.
- ow, w+cw, accumulator and output width; must be ≥ w+cw so a full dump never overflows.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a dump sequence when idle.
- stop  input  1  single-cycle pulse; aborts the sequence.
- cont  input  1  continuous mode, sampled at start.
- len  input  cw  dump length N, sampled at start.
- din  input  w  signed input sample.
- din_vld  input  1  din qualifier.
- dout  output  ow  signed dump value.
- dout_vld  output  1  dump available.
- dout_rdy  input  1  consumer accepts the dump when high together with dout_vld.
- busy  output  1  high while in ACC.
- ovr  output  1  sticky overrun flag.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE.
  - acc, cnt, dout, the latched len and the latched cont all cleared to 0.
  - dout_vld=0, busy=0, ovr=0.
- Clock domain: single domain; every register is on clk and is reset by rstn.
- State IDLE:
  - busy=0; din is ignored.
  - start=1 with len≠0: latch len→n_r and cont→cont_r, clear acc and cnt, clear ovr, go to ACC next cycle.
  - start=1 with len=0: ignored; stay in IDLE and do not touch ovr.
- State ACC:
  - busy=1; start is ignored.
  - Each cycle with din_vld=1: acc ← acc + sign-extended din, cnt ← cnt+1.
  - Final sample (din_vld=1 and cnt==n_r-1):
    - Dump value acc+din is loaded into dout; dout_vld=1 from the next cycle.
    - acc and cnt are cleared in the same cycle.
    - If cont_r=1, stay in ACC and start the next dump immediately with no gap sample; otherwise go to IDLE.
- Abort:
  - stop=1 in ACC: go to IDLE next cycle; acc and cnt are cleared and the partial sum is discarded.
  - A sample presented with stop in the same cycle is discarded, even if it is the final sample; no dump is produced.
  - stop in IDLE has no effect.
  - stop does not affect a pending dout/dout_vld.
- Output handshake:
  - dout_vld stays high and dout stays stable until a cycle with dout_rdy=1; dout_vld drops the next cycle unless a new dump loads in that same cycle.
  - New dump loads while dout_vld=1 and dout_rdy=0: dout is overwritten, dout_vld stays 1, ovr←1.
  - New dump loads in the same cycle as the handshake (dout_vld=1, dout_rdy=1): no overrun; dout_vld stays 1 with the new value.
- ovr is sticky: cleared only by reset or by an accepted start.
- Latency:
  - Final sample at cycle t gives dout_vld=1 at t+1.
  - start at cycle t gives busy=1 at t+1; the first sample is accepted at t+1.
- Arithmetic:
  - Full precision: ow-bit signed accumulation, no wrap or saturation for N ≤ 2^cw-1.
  - dout is the exact sum of the N samples.
- N=1: every valid sample dumps directly (dout = sign-extended din).
- Gaps in din_vld: accumulation pauses; cnt holds.

Test Plan:
- Single-shot N=4: din 5,−3,7,1 with din_vld continuous and dout_rdy=1 → one dump of dout=10, dout_vld high for 1 cycle, then busy=0.
- Continuous N=3 with defaults (w=10, cw=8): din=511 for 6 valid cycles, dout_rdy=1 → two dumps of 1533 back-to-back, three cycles apart. Then din=−512×255 with N=255 → dout=−130560, no overflow.
- Backpressure: N=2, cont=1, dout_rdy=0, din 1,2,3,4 → first dump 3, then overwrite with 7 and ovr=1. A subsequent start clears ovr. A dump load coinciding with dout_rdy=1 leaves ovr=0.
- Abort: N=8, feed 3 samples then stop → IDLE, no dout_vld. A restart with N=2 on din 4,4 gives dout=8, with no residue from the aborted sums.
- Gapped input and edge cases:
  - N=3 with din_vld pattern 1,0,0,1,0,1 on values 2,x,x,2,x,2 → dout=6 one cycle after the 6th cycle.
  - len=0 start → stays IDLE.
  - N=1 → dout equals each sample.
- Reset mid-operation: rstn low during ACC with dout_vld=1 and ovr=1 → all outputs 0 immediately (asynchronous). After release, IDLE ignores din until start.
